// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM encoding, instruction constants
// and the redirect-target alignment helper.
package rv32i_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_KILL = 2'd3;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Instructions are word aligned, so the low two target bits are discarded.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// Program counter for the fetch stage: redirect priority (branch/JAL over JALR),
// sequential +4 advance on a delivered instruction, otherwise hold.
module fetch_ctrl_pc
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_jal,
    input  logic        jalr,
    input  logic [31:0] branch_jump_address,
    input  logic [31:0] jalr_address,
    input  logic        advance_i,
    output logic        redirect_o,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] target_s;

    assign redirect_o = branch_jal | jalr;
    assign target_s   = align_target(branch_jal ? branch_jump_address : jalr_address);
    assign pc_o       = pc_q;

    // Next-pc selection; 32-bit addition wraps naturally at the top of memory.
    always_comb begin
        pc_d = pc_q;
        if (redirect_o) begin
            pc_d = target_s;
        end else if (advance_i) begin
            pc_d = pc_q + INSTR_BYTES;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: sequences one-outstanding imem fetches, applies redirects,
// holds on decode stall and drops responses of fetches made stale by a redirect.
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_jal,
    input  logic        jalr,
    input  logic [31:0] branch_jump_address,
    input  logic [31:0] jalr_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        flush
);

    state_t      state_q;
    state_t      state_d;
    logic        redirect_s;
    logic        deliver_s;
    logic [31:0] pc_s;
    logic        instr_valid_q;
    logic        instr_valid_d;
    logic [31:0] instr_out_q;
    logic [31:0] instr_out_d;
    logic [31:0] instr_pc_q;
    logic [31:0] instr_pc_d;
    logic        flush_q;

    fetch_ctrl_pc #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .clk                 (clk),
        .rst                 (rst),
        .branch_jal          (branch_jal),
        .jalr                (jalr),
        .branch_jump_address (branch_jump_address),
        .jalr_address        (jalr_address),
        .advance_i           (deliver_s),
        .redirect_o          (redirect_s),
        .pc_o                (pc_s)
    );

    // A held, undelivered word blocks a new request so it cannot be overwritten.
    assign imem_req  = (state_q == ST_REQ) && !(instr_valid_q && stall);
    assign imem_addr = pc_s;
    assign deliver_s = (state_q == ST_WAIT) && imem_rvalid && !redirect_s;

    // Fetch sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_req && imem_gnt) begin
                    state_d = redirect_s ? ST_KILL : ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else if (redirect_s) begin
                    state_d = ST_KILL;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_KILL: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_KILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IF/ID output: redirect kills, delivery loads, consumption clears, stall holds.
    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        if (redirect_s) begin
            instr_valid_d = 1'b0;
        end else if (deliver_s) begin
            instr_valid_d = 1'b1;
            instr_out_d   = imem_rdata;
            instr_pc_d    = pc_s;
        end else if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
        end else begin
            instr_valid_d = instr_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            instr_valid_q <= 1'b0;
            instr_out_q   <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            flush_q       <= redirect_s;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign flush       = flush_q;

endmodule
